// File: rtl/ring_mon_pkg.sv
// Shared definitions for ring oscillator measurement blocks.
// Holds the measurement FSM state encoding and the default parameter values.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLD    = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_WINDOW       = 1024;
  localparam int DEF_STALL_CYCLES = 64;
  localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/ring_osc_monitor_if.sv
// Result channel of the ring oscillator monitor.
//   count_data  : rising-edge count of the last window
//   count_valid : result available
//   count_ready : consumer accepts result
//   stalled     : sticky, ring was quiet for too long during the window
//   overflow    : sticky, edge count saturated
// master = monitor side, slave = consumer side.
interface ring_osc_monitor_if
  import ring_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic [CNT_W-1:0] count_data;
  logic             count_valid;
  logic             count_ready;
  logic             stalled;
  logic             overflow;

  modport master (output count_data, count_valid, stalled, overflow, input count_ready);
  modport slave  (input count_data, count_valid, stalled, overflow, output count_ready);
endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, all stages clear to 0
//   d     : asynchronous input
//   q     : synchronised output, STAGES cycles of latency
module sync_ff
  import ring_mon_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/ring_osc_monitor.sv
// Ring oscillator edge counter.
// Synchronises one ring tap, counts its rising edges over a WINDOW-cycle
// measurement and returns the count over a valid/ready channel together with
// stall and saturation flags.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ring_in    : asynchronous ring tap
//   start      : begin a measurement (IDLE, or HOLD on the handshake cycle)
//   busy       : high while measuring or holding a result
//   res        : result channel (count, flags, valid/ready)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; flags of the last window still readable
// ST_MEASURE | counting edges, window timer running down to 0
// ST_HOLD    | result presented, waiting for the consumer handshake
module ring_osc_monitor
  import ring_mon_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ring_in,
  input  logic start,
  output logic busy,
  ring_osc_monitor_if.master res
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int STL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
  localparam logic [STL_W-1:0] STL_TC   = STL_W'(STALL_CYCLES);

  mon_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [STL_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             stalled_q, stalled_d;
  logic             overflow_q, overflow_d;
  logic             ring_p_q, ring_p_d;
  logic             ring_s, rise, trans, arm;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ring_in),
    .q     (ring_s)
  );

  assign rise  = ring_s & ~ring_p_q;
  assign trans = ring_s ^ ring_p_q;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    stl_d      = stl_q;
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    stalled_d  = stalled_q;
    overflow_d = overflow_q;
    // ring_p always follows ring_s, so the first window cycle compares against
    // the tap value seen when start was taken and never sees a fake edge.
    ring_p_d   = ring_s;
    arm        = 1'b0;

    unique case (state_q)
      ST_IDLE: arm = start;
      ST_MEASURE: begin
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) overflow_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (trans)                 stl_d = '0;
        else if (stl_q != STL_TC)  stl_d = stl_q + 1'b1;
        if (stl_d == STL_TC) stalled_d = 1'b1;
        // Terminal count: this cycle's edge is still included in the result.
        if (win_q == '0) begin
          state_d = ST_HOLD;
          data_d  = edge_cnt_d;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (res.count_ready) begin
          arm = start;
          if (!start) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arm) begin
      state_d    = ST_MEASURE;
      win_d      = WIN_LOAD;
      stl_d      = '0;
      edge_cnt_d = '0;
      stalled_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      stl_q      <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      stalled_q  <= 1'b0;
      overflow_q <= 1'b0;
      ring_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      stl_q      <= stl_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      stalled_q  <= stalled_d;
      overflow_q <= overflow_d;
      ring_p_q   <= ring_p_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign res.count_valid = (state_q == ST_HOLD);
  assign res.count_data  = data_q;
  assign res.stalled     = stalled_q;
  assign res.overflow    = overflow_q;
endmodule

// File: tb/tb_ring_osc_monitor.sv
module tb_ring_osc_monitor;
  import ring_mon_pkg::*;

  localparam int W    = 100;
  localparam int STL  = 64;
  localparam int L    = 2;
  localparam int CW   = 16;
  localparam int CW2  = 4;
  localparam int HMAX = 16384;

  typedef struct {
    int data;
    bit stl;
    bit ovf;
    int vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ring_in = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic busy, busy2;
  int   cyc = 0;
  bit   wave [HMAX];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  ring_osc_monitor_if #(.CNT_W(CW))  rif();
  ring_osc_monitor_if #(.CNT_W(CW2)) rif2();

  ring_osc_monitor #(.CNT_W(CW), .WINDOW(W), .STALL_CYCLES(STL), .SYNC_STAGES(L)) dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start), .busy(busy), .res(rif)
  );

  ring_osc_monitor #(.CNT_W(CW2), .WINDOW(W), .STALL_CYCLES(STL), .SYNC_STAGES(L)) dut2 (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start2), .busy(busy2), .res(rif2)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit wv(int j);
    return wave[((j % HMAX) + HMAX) % HMAX];
  endfunction

  // Ring value sampled at posedge k is wave[k].
  task automatic tick();
    @(posedge clk);
    #1;
    ring_in = wv(cyc);
    if (rdy_mode == 0) rif.count_ready = ($urandom_range(0, 3) != 0);
    else               rif.count_ready = (rdy_mode == 1);
  endtask

  task automatic fill(int pat, int len);
    int half = $urandom_range(1, 12);
    int ph   = $urandom_range(0, 23);
    bit v    = wv(cyc + 2);
    for (int j = cyc + 3; j < cyc + 3 + len; j++) begin
      case (pat)
        0:       v = (((j + ph) / half) % 2) == 1;
        1:       if ($urandom_range(0, 2) == 0) v = ~v;
        2:       if ($urandom_range(0, 59) == 0) v = ~v;
        4:       v = (j % 5) < 2;
        default: v = 1'b0;
      endcase
      wave[j % HMAX] = v;
    end
  endtask

  // Window whose start is taken at posedge s: the synchronised tap seen during
  // the WINDOW measuring cycles corresponds to ring samples s+1-L .. s+W-L.
  function automatic exp_t model(int s, int cw);
    exp_t e;
    int edges = 0;
    int quiet = 0;
    int maxv  = (1 << cw) - 1;
    e.stl = 1'b0;
    for (int j = s + 1 - L; j <= s + W - L; j++)
      if (wv(j) && !wv(j - 1)) edges++;
    for (int j = s + 1 - L; j <= s + W - L; j++) begin
      if (wv(j) != wv(j - 1)) quiet = 0;
      else                    quiet++;
      if (quiet >= STL) e.stl = 1'b1;
    end
    e.data = (edges > maxv) ? maxv : edges;
    e.ovf  = (edges > maxv);
    e.vcyc = s + W + 1;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy || rif.count_valid) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", longint'(n < 400), 1);
  endtask

  task automatic run_window(int pat);
    fill(pat, W + 40);
    repeat (6) tick();
    sb.push_back(model(cyc, CW));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_idle();
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    logic          v_prev = 1'b0;
    int            rise_cyc = 0;
    logic [CW-1:0] held_d = '0;
    logic          held_s = 1'b0;
    logic          held_o = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v_prev = 1'b0;
      end else begin
        if (rif.count_valid) begin
          chk("busy_in_hold", busy, 1);
          if (!v_prev) begin
            rise_cyc = cyc;
            held_d   = rif.count_data;
            held_s   = rif.stalled;
            held_o   = rif.overflow;
          end else begin
            chk("hold_data_stable", rif.count_data, held_d);
            chk("hold_stalled_stable", rif.stalled, held_s);
            chk("hold_overflow_stable", rif.overflow, held_o);
          end
          if (rif.count_ready) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result: got data %0d, expected no result", rif.count_data);
            end else begin
              e = sb.pop_front();
              chk("count_data", rif.count_data, e.data);
              chk("stalled", rif.stalled, e.stl);
              chk("overflow", rif.overflow, e.ovf);
              chk("valid_rise_cycle", rise_cyc, e.vcyc);
            end
          end
        end
        v_prev = rif.count_valid;
      end
    end
  end

  initial begin
    exp_t e;
    int   s, s2, n, lowc;
    bit   seen;

    rif.count_ready  = 1'b0;
    rif2.count_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.count_valid, 0);
    chk("rst_data", rif.count_data, 0);
    chk("rst_stalled", rif.stalled, 0);
    chk("rst_overflow", rif.overflow, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Period 10, first rising edge 5 cycles into the window: exactly 10 edges.
    for (int j = cyc + 3; j < cyc + 3 + W + 40; j++)
      wave[j % HMAX] = ((j - (cyc + 11) + 1000) % 10) < 5;
    repeat (6) tick();
    s = cyc;
    e.data = 10; e.stl = 1'b0; e.ovf = 1'b0; e.vcyc = s + W + 1;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 10; i++) run_window($urandom_range(0, 2));

    // Stalled ring: flag appears after 64 quiet window cycles.
    fill(3, W + 40);
    repeat (6) tick();
    s = cyc;
    e.data = 0; e.stl = 1'b1; e.ovf = 1'b0; e.vcyc = s + W + 1;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < s + STL) tick();
    chk("stall_before_64", rif.stalled, 0);
    tick();
    chk("stall_at_64", rif.stalled, 1);
    wait_idle();
    chk("stall_sticky_idle", rif.stalled, 1);

    // Backpressure with start pulsed during HOLD.
    rdy_mode = 2;
    fill(0, W + 60);
    repeat (6) tick();
    sb.push_back(model(cyc, CW));
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!rif.count_valid && n < 200) begin tick(); n++; end
    chk("bp_valid_timeout", longint'(n < 200), 1);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("bp_still_valid", rif.count_valid, 1);
    rdy_mode = 1;
    tick();
    tick();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", rif.count_valid, 0);

    // Back-to-back windows via handshake + start.
    rdy_mode = 2;
    fill(1, 2 * W + 60);
    repeat (6) tick();
    s = cyc;
    sb.push_back(model(s, CW));
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < s + W + 1) tick();
    chk("b2b_first_valid", rif.count_valid, 1);
    s2 = cyc;
    sb.push_back(model(s2, CW));
    rdy_mode = 1;
    rif.count_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy_mode = 2;
    chk("b2b_valid_dropped", rif.count_valid, 0);
    lowc = 0;
    while (cyc < s2 + W + 1) begin
      if (!busy) lowc++;
      tick();
    end
    chk("b2b_busy_low_cycles", lowc, 0);
    chk("b2b_second_valid", rif.count_valid, 1);
    rdy_mode = 0;
    wait_idle();

    // Saturation on the 4-bit instance: 20 edges in the window.
    fill(4, W + 40);
    repeat (6) tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!rif2.count_valid && n < 200) begin tick(); n++; end
    chk("ovf_valid_timeout", longint'(n < 200), 1);
    chk("ovf_count_data", rif2.count_data, 15);
    chk("ovf_overflow", rif2.overflow, 1);
    chk("ovf_stalled", rif2.stalled, 0);
    tick();
    tick();
    chk("ovf_idle_busy", busy2, 0);
    chk("ovf_sticky_idle", rif2.overflow, 1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("ovf_cleared_by_start", rif2.overflow, 0);
    chk("ovf_busy_restart", busy2, 1);

    // Asynchronous reset while holding an unconsumed result.
    rdy_mode = 2;
    fill(2, W + 40);
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 10) tick();
    chk("pre_reset_valid", rif.count_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rif.count_valid, 0);
    chk("midrst_data", rif.count_data, 0);
    chk("midrst_stalled", rif.stalled, 0);
    chk("midrst_overflow", rif.overflow, 0);
    chk("midrst_busy2", busy2, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    seen = 1'b0;
    repeat (W + 20) begin
      tick();
      if (rif.count_valid || busy) seen = 1'b1;
    end
    chk("no_result_after_reset", seen, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
